// File: rtl/blake2_block_loader.sv
// Packs a narrow little-endian byte stream into zero-padded BLAKE2 message blocks
// and presents each block, with its byte counter t and final flag, over valid/ready.
module blake2_block_loader #(
    parameter int unsigned IN_W        = 8,
    parameter int unsigned WORD_W      = 64,
    parameter int unsigned BLOCK_WORDS = 16,
    parameter int unsigned CNT_W       = 64,
    localparam int unsigned BPB         = IN_W / 8,
    localparam int unsigned BLOCK_BYTES = BLOCK_WORDS * WORD_W / 8,
    localparam int unsigned BLK_W       = BLOCK_BYTES * 8,
    localparam int unsigned IB_W        = $clog2(BPB + 1),
    localparam int unsigned FILL_W      = $clog2(BLOCK_BYTES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [IN_W-1:0]   in_data,
    input  logic              in_last,
    input  logic [IB_W-1:0]   in_bytes,
    output logic              in_ready,
    output logic              blk_valid,
    input  logic              blk_ready,
    output logic [BLK_W-1:0]  blk_data,
    output logic [FILL_W-1:0] blk_bytes,
    output logic [CNT_W-1:0]  blk_t,
    output logic              blk_last,
    output logic              err
);

    typedef enum logic {S_FILL, S_HOLD} state_e;

    state_e            state_q, state_d;
    logic [BLK_W-1:0]  buf_q, buf_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [CNT_W-1:0]  t_q, t_d;
    logic [FILL_W-1:0] bytes_q, bytes_d;
    logic [CNT_W-1:0]  blk_t_q, blk_t_d;
    logic              last_q, last_d;
    logic              err_q, err_d;
    logic              ready_q, ready_d;
    logic              valid_q, valid_d;

    int unsigned       n_c;
    logic              bad_len_c;
    logic [IN_W-1:0]   beat_c;
    logic [FILL_W-1:0] fill_new_c;
    logic [CNT_W-1:0]  t_new_c;
    logic              accept_c;

    // Effective byte count of the beat; oversize counts clamp to a full beat
    always_comb begin
        n_c       = BPB;
        bad_len_c = 1'b0;
        if (in_last) begin
            if (in_bytes > IB_W'(BPB)) begin
                bad_len_c = 1'b1;
            end else begin
                n_c = 32'(in_bytes);
            end
        end
        beat_c = '0;
        for (int unsigned j = 0; j < BPB; j++) begin
            if (j < n_c) beat_c[j*8 +: 8] = in_data[j*8 +: 8];
        end
        fill_new_c = fill_q + FILL_W'(n_c);
        t_new_c    = t_q + CNT_W'(n_c);
        accept_c   = in_valid && ready_q;
    end

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        fill_d  = fill_q;
        t_d     = t_q;
        bytes_d = bytes_q;
        blk_t_d = blk_t_q;
        last_d  = last_q;
        err_d   = err_q;
        case (state_q)
            S_FILL: begin
                if (accept_c) begin
                    // Target bytes are still zero from the last clear, so OR-ing is a write
                    buf_d  = buf_q | (BLK_W'(beat_c) << (8 * 32'(fill_q)));
                    fill_d = fill_new_c;
                    t_d    = t_new_c;
                    if (bad_len_c || (in_last && n_c == 0 && fill_q == '0 && t_q != '0)) begin
                        err_d = 1'b1;
                    end
                    if (in_last || fill_new_c == FILL_W'(BLOCK_BYTES)) begin
                        state_d = S_HOLD;
                        bytes_d = fill_new_c;
                        blk_t_d = t_new_c;
                        last_d  = in_last;
                    end
                end
            end
            S_HOLD: begin
                if (blk_ready) begin
                    state_d = S_FILL;
                    buf_d   = '0;
                    fill_d  = '0;
                    if (last_q) t_d = '0;
                end
            end
            default: state_d = S_FILL;
        endcase
        ready_d = (state_d == S_FILL);
        valid_d = (state_d == S_HOLD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FILL;
            buf_q   <= '0;
            fill_q  <= '0;
            t_q     <= '0;
            bytes_q <= '0;
            blk_t_q <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            fill_q  <= fill_d;
            t_q     <= t_d;
            bytes_q <= bytes_d;
            blk_t_q <= blk_t_d;
            last_q  <= last_d;
            err_q   <= err_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
        end
    end

    assign in_ready  = ready_q;
    assign blk_valid = valid_q;
    assign blk_data  = buf_q;
    assign blk_bytes = bytes_q;
    assign blk_t     = blk_t_q;
    assign blk_last  = last_q;
    assign err       = err_q;

endmodule

// File: tb/tb_blake2_block_loader.sv
// Directed bench for blake2_block_loader: default BLAKE2b/8-bit build plus a 32-bit BLAKE2s build.
module tb_blake2_block_loader;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Default build: BPB=1, 128-byte blocks
    logic          in_valid, in_last, in_ready, blk_valid, blk_ready, blk_last, err;
    logic [7:0]    in_data;
    logic [0:0]    in_bytes;
    logic [1023:0] blk_data;
    logic [7:0]    blk_bytes;
    logic [63:0]   blk_t;

    // 32-bit pins, 32-bit words: BPB=4, 64-byte blocks
    logic          in_valid2, in_last2, in_ready2, blk_valid2, blk_ready2, blk_last2, err2;
    logic [31:0]   in_data2;
    logic [2:0]    in_bytes2;
    logic [511:0]  blk_data2;
    logic [6:0]    blk_bytes2;
    logic [63:0]   blk_t2;

    blake2_block_loader u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_bytes(in_bytes), .in_ready(in_ready), .blk_valid(blk_valid), .blk_ready(blk_ready),
        .blk_data(blk_data), .blk_bytes(blk_bytes), .blk_t(blk_t), .blk_last(blk_last), .err(err)
    );

    blake2_block_loader #(.IN_W(32), .WORD_W(32), .BLOCK_WORDS(16), .CNT_W(64)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_data(in_data2), .in_last(in_last2),
        .in_bytes(in_bytes2), .in_ready(in_ready2), .blk_valid(blk_valid2), .blk_ready(blk_ready2),
        .blk_data(blk_data2), .blk_bytes(blk_bytes2), .blk_t(blk_t2), .blk_last(blk_last2), .err(err2)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          len;
        logic [7:0]  base;
        logic [63:0] e_bytes;
        logic [63:0] e_t;
        logic [63:0] e_last;
        logic [63:0] e_lo;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chkw(input string nm, input logic [1023:0] act, input logic [1023:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: in_ready never rose within 64 cycles", nm);
    endtask

    task automatic send_beat(input logic [7:0] d, input logic last, input logic nb);
        int k;
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_last = last; in_bytes = nb;
        k = 0;
        while (!in_ready && k < 64) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) timeout("send_beat");
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic send32(input logic [31:0] d, input logic last, input logic [2:0] nb);
        int k;
        @(negedge clk);
        in_valid2 = 1'b1; in_data2 = d; in_last2 = last; in_bytes2 = nb;
        k = 0;
        while (!in_ready2 && k < 64) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready2) timeout("send32");
        @(posedge clk);
        #1;
        in_valid2 = 1'b0; in_last2 = 1'b0;
    endtask

    task automatic send_msg(input int len, input logic [7:0] base);
        if (len == 0) begin
            send_beat(8'h00, 1'b1, 1'b0);
        end else begin
            for (int i = 0; i < len; i++) send_beat(8'(base + 8'(i)), (i == len - 1), 1'b1);
        end
    endtask

    task automatic take_block;
        @(negedge clk);
        blk_ready = 1'b1;
        @(posedge clk);
        #1;
        blk_ready = 1'b0;
    endtask

    task automatic check_blk(input string nm, input logic [63:0] eb, input logic [63:0] et,
                             input logic [63:0] el, input logic [63:0] ee);
        chk({nm, ".valid"}, 64'(blk_valid), 64'd1);
        chk({nm, ".in_ready"}, 64'(in_ready), 64'd0);
        chk({nm, ".bytes"}, 64'(blk_bytes), eb);
        chk({nm, ".t"}, blk_t, et);
        chk({nm, ".last"}, 64'(blk_last), el);
        chk({nm, ".err"}, 64'(err), ee);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1023:0] exp_blk;
        logic [7:0]    e_bytes;
        logic [63:0]   e_t;

        vecs[0] = '{len: 0,   base: 8'h00, e_bytes: 0,   e_t: 0,   e_last: 1, e_lo: 64'h0};
        vecs[1] = '{len: 3,   base: 8'h61, e_bytes: 3,   e_t: 3,   e_last: 1, e_lo: 64'h636261};
        vecs[2] = '{len: 5,   base: 8'h10, e_bytes: 5,   e_t: 5,   e_last: 1, e_lo: 64'h14_1312_1110};
        vecs[3] = '{len: 1,   base: 8'hFF, e_bytes: 1,   e_t: 1,   e_last: 1, e_lo: 64'hFF};
        vecs[4] = '{len: 128, base: 8'h00, e_bytes: 128, e_t: 128, e_last: 1, e_lo: 64'h0706050403020100};

        rst = 1'b1;
        in_valid = 0; in_data = 0; in_last = 0; in_bytes = 0; blk_ready = 0;
        in_valid2 = 0; in_data2 = 0; in_last2 = 0; in_bytes2 = 0; blk_ready2 = 0;
        #12;
        chk("reset.valid", 64'(blk_valid), 64'd0);
        chk("reset.bytes", 64'(blk_bytes), 64'd0);
        chk("reset.t", blk_t, 64'd0);
        chk("reset.last", 64'(blk_last), 64'd0);
        chk("reset.err", 64'(err), 64'd0);
        chkw("reset.data", blk_data, 1024'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset.in_ready", 64'(in_ready), 64'd1);

        // Single-block messages from the table
        foreach (vecs[v]) begin
            send_msg(vecs[v].len, vecs[v].base);
            check_blk($sformatf("vec%0d", v), vecs[v].e_bytes, vecs[v].e_t, vecs[v].e_last, 64'd0);
            chk($sformatf("vec%0d.lo", v), blk_data[63:0], vecs[v].e_lo);
            exp_blk = '0;
            for (int k = 0; k < vecs[v].len; k++) exp_blk[k*8 +: 8] = 8'(vecs[v].base + 8'(k));
            chkw($sformatf("vec%0d.data", v), blk_data, exp_blk);
            take_block();
            chk($sformatf("vec%0d.released", v), 64'(blk_valid), 64'd0);
        end

        // 129-byte message across two blocks
        for (int i = 0; i < 128; i++) send_beat(8'(i), 1'b0, 1'b1);
        check_blk("m129a", 64'd128, 64'd128, 64'd0, 64'd0);
        chk("m129a.b127", 64'(blk_data[1023:1016]), 64'h7F);
        take_block();
        send_beat(8'h80, 1'b1, 1'b1);
        check_blk("m129b", 64'd1, 64'd129, 64'd1, 64'd0);
        chkw("m129b.data", blk_data, 1024'h80);
        take_block();

        // Backpressure with a pending beat of the next message
        send_beat(8'h78, 1'b0, 1'b1);
        send_beat(8'h79, 1'b1, 1'b1);
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h55; in_last = 1'b1; in_bytes = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_blk($sformatf("bp%0d", c), 64'd2, 64'd2, 64'd1, 64'd0);
            chk($sformatf("bp%0d.data", c), blk_data[63:0], 64'h7978);
        end
        blk_ready = 1'b1;
        @(posedge clk);
        #1;
        blk_ready = 1'b0;
        chk("bp.after_handoff.valid", 64'(blk_valid), 64'd0);
        chk("bp.after_handoff.in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_last = 1'b0;
        check_blk("bp.next", 64'd1, 64'd1, 64'd1, 64'd0);
        chkw("bp.next.data", blk_data, 1024'h55);
        take_block();

        // 32-bit build: partial last beat and oversize in_bytes
        send32(32'h44332211, 1'b0, 3'd0);
        send32(32'hDDCCBBAA, 1'b1, 3'd2);
        chk("w32.valid", 64'(blk_valid2), 64'd1);
        chk("w32.bytes", 64'(blk_bytes2), 64'd6);
        chk("w32.t", blk_t2, 64'd6);
        chk("w32.last", 64'(blk_last2), 64'd1);
        chk("w32.err", 64'(err2), 64'd0);
        chkw("w32.data", {512'd0, blk_data2}, 1024'hBBAA_4433_2211);
        @(negedge clk);
        blk_ready2 = 1'b1;
        @(posedge clk);
        #1;
        blk_ready2 = 1'b0;
        send32(32'h11223344, 1'b1, 3'd7);
        chk("w32ovr.bytes", 64'(blk_bytes2), 64'd4);
        chk("w32ovr.t", blk_t2, 64'd4);
        chk("w32ovr.err", 64'(err2), 64'd1);
        chkw("w32ovr.data", {512'd0, blk_data2}, 1024'h1122_3344);

        // Empty last beat after a full block: error, zero block
        for (int i = 0; i < 128; i++) send_beat(8'(i + 3), 1'b0, 1'b1);
        check_blk("errpre", 64'd128, 64'd128, 64'd0, 64'd0);
        take_block();
        send_beat(8'hEE, 1'b1, 1'b0);
        check_blk("err", 64'd0, 64'd128, 64'd1, 64'd1);
        chkw("err.data", blk_data, 1024'd0);
        take_block();
        chk("err.sticky", 64'(err), 64'd1);

        // Asynchronous reset mid-FILL
        send_beat(8'hA1, 1'b0, 1'b1);
        send_beat(8'hA2, 1'b0, 1'b1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst.err", 64'(err), 64'd0);
        chk("arst.valid", 64'(blk_valid), 64'd0);
        chk("arst.err2", 64'(err2), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        send_beat(8'h5A, 1'b1, 1'b1);
        check_blk("arst.next", 64'd1, 64'd1, 64'd1, 64'd0);
        chkw("arst.next.data", blk_data, 1024'h5A);
        take_block();

        e_bytes = blk_bytes;
        e_t = blk_t;
        chk("arst.hold_after_take.bytes", 64'(e_bytes), 64'd1);
        chk("arst.hold_after_take.t", e_t, 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/blake2_block_loader.md
Name: blake2_block_loader

Overview:
Parametrised input-side block assembler for the BLAKE2 core. It accepts message bytes from the narrow pin-level stream, packs them little-endian into a zero-padded BLOCK_WORDS x WORD_W message block, and hands the block to the compression core over a valid/ready handshake. With each block it also reports the cumulative byte counter t and the final-block flag. Stream width, word width, block size and counter width are all generic, so the same block serves BLAKE2s and BLAKE2b builds and 8/16/32-bit pin buses.

Parameters:
IN_W, 8, input beat width in bits; multiple of 8; IN_W/8 = BPB bytes per beat
WORD_W, 64, message word width (32 for BLAKE2s, 64 for BLAKE2b)
BLOCK_WORDS, 16, words per block; BLOCK_BYTES = BLOCK_WORDS*WORD_W/8, a multiple of BPB
CNT_W, 64, width of the byte counter t

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  beat present
in_data  in  IN_W  beat bytes; byte j = in_data[8j+7:8j], lowest byte first in stream order
in_last  in  1  beat is the final beat of the message
in_bytes  in  $clog2(BPB+1)  valid bytes in a last beat, 0..BPB; ignored when in_last=0
in_ready  out  1  loader accepts a beat
blk_valid  out  1  block available
blk_ready  in  1  core takes the block
blk_data  out  BLOCK_BYTES*8  block; stream byte k of the block at bits [8k+7:8k]
blk_bytes  out  $clog2(BLOCK_BYTES+1)  message bytes in this block
blk_t  out  CNT_W  cumulative message bytes up to and including this block
blk_last  out  1  final block of the message
err  out  1  sticky protocol error

Behaviour:
- Reset: async on rst=1. State FILL, buffer all zeros, fill=0, t=0, blk_valid=0, blk_bytes=0, blk_t=0, blk_last=0, err=0. In FILL, in_ready=1 one cycle after reset is released.
- States: FILL and HOLD. in_ready = (state==FILL). blk_valid = (state==HOLD).
- Beat acceptance: a beat is accepted when in_valid && in_ready. Bytes written per beat: n = BPB if in_last=0, otherwise in_bytes. The beat writes bytes fill..fill+n-1. fill += n and t += n, with t wrapping modulo 2^CNT_W. Bytes at or above index n in the beat are discarded and are not written.
- FILL -> HOLD: taken on the accepting edge when the new fill equals BLOCK_BYTES, or when in_last=1. On that edge blk_bytes = new fill, blk_t = new t, and blk_last = in_last.
- A full block without in_last is emitted with blk_last=0. Upstream must assert in_last on the final data beat.
- Zero padding: unwritten bytes stay zero because the buffer is cleared on every hand-off.
- HOLD: blk_data, blk_bytes, blk_t and blk_last are held stable. in_ready=0.
- HOLD -> FILL: when blk_ready=1, the edge clears the buffer and sets fill=0. If blk_last=1, t is also cleared to 0 so the next message starts fresh. Latency is one cycle from the final accepted beat to blk_valid. There is at least one idle input cycle per block, with no bypass.
- Empty message: in_last with in_bytes=0 while t=0 and fill=0 emits an all-zero block with blk_bytes=0, blk_t=0, blk_last=1.
- Error case: in_last with in_bytes=0 while fill=0 and t!=0 still emits a zero block with blk_last=1, and sets err. err is also set when in_bytes>BPB; in that case the beat is treated as in_bytes=BPB. err clears only on rst.
- blk_ready while in FILL is ignored. in_valid while in HOLD is not consumed.
- Reset during HOLD or mid-FILL: outputs return to their reset values immediately and the partial message is lost.

Test Plan:
1. Empty message (default params): one beat, in_last=1, in_bytes=0 -> next cycle blk_valid=1, blk_data=0, blk_bytes=0, blk_t=0, blk_last=1, err=0.
2. "abc": beats 0x61, 0x62, then 0x63 with in_last=1, in_bytes=1 -> blk_data[23:0]=0x636261, all higher bits 0, blk_bytes=3, blk_t=3, blk_last=1.
3. 129 bytes of value i&0xFF, blk_ready=1:
   - first block: blk_bytes=128, blk_t=128, blk_last=0, byte 127 = 0x7F.
   - second block: blk_bytes=1, blk_t=129, blk_last=1, blk_data[7:0]=0x80.
   - in_ready=0 in both HOLD cycles.
4. Backpressure: hold blk_ready=0 for 5 cycles in HOLD -> blk_* constant, in_ready=0, and a held in_valid beat is consumed only after the hand-off edge. Then send a second message -> its blk_t restarts from its own byte count.
5. IN_W=32, WORD_W=32, BLOCK_WORDS=16: beat 0x44332211, then last beat 0xDDCCBBAA with in_bytes=2 -> block bytes 11 22 33 44 AA BB, then zeros; blk_bytes=6, blk_t=6.
6. Error and reset: after 128 bytes emitted with last=0, send a last beat with in_bytes=0 -> zero block with blk_last=1, blk_t=128, err=1. Then pulse rst mid-FILL -> err=0, blk_valid=0 asynchronously, and the next message counts t from 0.
